// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types for the reset sequencer.
// FSM state encoding and a counter-width helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Bits needed to hold counts 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// reset_sync: 2-flop synchroniser, async assert / sync deassert.
// clk_i, rst_ni (async, active low), d_i level in, q_o synced out.
module reset_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff1_q <= RST_VAL;
            ff2_q <= RST_VAL;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on hold then staggered release of N_CH resets.
// Ports: clk, reset_n (async low), sw (raw switch), rst_out[N_CH], ready.
// Optional switch debouncer: define RESET_SEQ_DEBOUNCE_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int HOLD_CYCLES     = 64,
    parameter int STAGGER_CYCLES  = 4,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int SW_ACTIVE_HIGH  = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sw,
    output logic [N_CH-1:0] rst_out,
    output logic            ready
);

    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int SW = cnt_w(STAGGER_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STAG_MAX = SW'(STAGGER_CYCLES - 1);
    // Raw switch level that means "not pressed".
    localparam logic SW_REL = (SW_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

    logic rst_sync_n;
    logic sw_sync;
    logic pressed_raw;
    logic pressed;

    reset_sync #(
        .RST_VAL(1'b0)
    ) u_rst_sync (
        .clk_i (clk),
        .rst_ni(reset_n),
        .d_i   (1'b1),
        .q_o   (rst_sync_n)
    );

    reset_sync #(
        .RST_VAL(SW_REL)
    ) u_sw_sync (
        .clk_i (clk),
        .rst_ni(reset_n),
        .d_i   (sw),
        .q_o   (sw_sync)
    );

    assign pressed_raw = sw_sync ^ SW_REL;

`ifdef RESET_SEQ_DEBOUNCE_EN
    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic          db_q;
    logic          db_d;
    logic [DW-1:0] dbc_q;
    logic [DW-1:0] dbc_d;

    // Accept a new level only after it differs for DEBOUNCE_CYCLES
    // consecutive edges; any return to the old level restarts the run.
    always_comb begin
        db_d  = db_q;
        dbc_d = '0;
        if (pressed_raw != db_q) begin
            if (dbc_q == DB_MAX) begin
                db_d  = pressed_raw;
            end else begin
                dbc_d = dbc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q  <= 1'b0;
            dbc_q <= '0;
        end else begin
            db_q  <= db_d;
            dbc_q <= dbc_d;
        end
    end

    assign pressed = db_q;
`else
    assign pressed = pressed_raw;
`endif

    state_e         state_q;
    state_e         state_d;
    logic [HW-1:0]  hold_q;
    logic [HW-1:0]  hold_d;
    logic [SW-1:0]  stag_q;
    logic [SW-1:0]  stag_d;
    logic [N_CH-1:0] rst_q;
    logic [N_CH-1:0] rst_d;
    logic           ready_q;
    logic           ready_d;

    // Channels release LSB first: shifting a zero in from the bottom
    // keeps the vector thermometer-shaped, so ordering is monotonic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stag_d  = stag_q;
        rst_d   = rst_q;
        ready_d = (state_q == ST_RUN);
        if (pressed) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            stag_d  = '0;
            rst_d   = '1;
            ready_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_MAX) begin
                        stag_d  = '0;
                        rst_d   = rst_q << 1;
                        state_d = (rst_d == '0) ? ST_RUN : ST_RELEASE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (stag_q == STAG_MAX) begin
                        stag_d = '0;
                        rst_d  = rst_q << 1;
                        if (rst_d == '0) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        stag_d = stag_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_d = '0;
                end
                default: begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    rst_d   = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            stag_q  <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stag_q  <= stag_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    assign rst_out = rst_q;
    assign ready   = ready_q;

endmodule
